alu_arbiter: RTL and testbench

Round-robin arbiter and sequencer sharing one `alu` instance (N-bit, 3-bit opcode) among R requesters. Accepts one request at a time, latches its opcode and operands, drives the internal `alu`, registers the result, and returns it with a one-cycle completion pulse to the owning requester. Sits between client blocks and the single ALU datapath so that only this block instantiates `alu`.

---
 rtl/alu_arbiter.sv | 178 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter (with internal alu)
// Brief    : Round-robin arbiter/sequencer sharing a single ALU among R
//            requesters. IDLE -> EXEC -> DONE -> IDLE, one op per 3 cycles.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef ALU_ADD
`define ALU_ADD 3'd0
`endif
`ifndef ALU_SUB
`define ALU_SUB 3'd1
`endif
`ifndef ALU_OR
`define ALU_OR  3'd2
`endif
`ifndef ALU_AND
`define ALU_AND 3'd3
`endif

module alu #(
   parameter int N = 16
) (
   input  logic [2:0]   op,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] y
);
   // Pure combinational datapath; undefined opcodes yield zero.
   always_comb begin
      y = '0;
      case (op)
         `ALU_ADD: y = a + b;
         `ALU_SUB: y = a - b;
         `ALU_OR:  y = a | b;
         `ALU_AND: y = a & b;
         default:  y = '0;
      endcase
   end
endmodule

module alu_arbiter #(
   parameter int N = 16,
   parameter int R = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [R-1:0]     req,
   input  logic [3*R-1:0]   opcode_in,
   input  logic [N*R-1:0]   a_in,
   input  logic [N*R-1:0]   b_in,
   output logic [R-1:0]     gnt,
   output logic [R-1:0]     done,
   output logic [N-1:0]     result,
   output logic             busy
);
   localparam int PW = (R > 1) ? $clog2(R) : 1;
   localparam int SW = PW + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [PW-1:0]   r_ptr;
   logic [PW-1:0]   r_owner;
   logic [2:0]      r_op;
   logic [N-1:0]    r_a;
   logic [N-1:0]    r_b;
   logic            w_found;
   logic [PW-1:0]   w_win;
   logic [PW-1:0]   w_ptr_next;
   logic [SW-1:0]   w_sum;
   logic [N-1:0]    w_alu_y;

   // The ALU only ever sees latched operands, so live inputs cannot disturb EXEC.
   alu #(.N(N)) u_alu (
      .op (r_op),
      .a  (r_a),
      .b  (r_b),
      .y  (w_alu_y)
   );

   // Round-robin search: first set request starting at ptr, wrapping mod R.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_sum   = '0;
      for (int i = 0; i < R; i++) begin
         w_sum = {1'b0, r_ptr} + SW'(i);
         if (w_sum >= SW'(R)) begin
            w_sum = w_sum - SW'(R);
         end
         if (!w_found && req[w_sum[PW-1:0]]) begin
            w_found = 1'b1;
            w_win   = w_sum[PW-1:0];
         end
      end
      w_ptr_next = (w_win == PW'(R - 1)) ? '0 : w_win + PW'(1);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic and busy flag; requests only matter in IDLE.
   always_comb begin
      w_next = r_state;
      busy   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_next = S_EXEC;
            end
         end
         S_EXEC: begin
            busy   = 1'b1;
            w_next = S_DONE;
         end
         S_DONE: begin
            busy   = 1'b1;
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Datapath: operand capture on grant, result capture in EXEC, one-cycle pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr   <= '0;
         r_owner <= '0;
         r_op    <= '0;
         r_a     <= '0;
         r_b     <= '0;
         gnt     <= '0;
         done    <= '0;
         result  <= '0;
      end else begin
         gnt <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_op    <= opcode_in[3*w_win +: 3];
                  r_a     <= a_in[N*w_win +: N];
                  r_b     <= b_in[N*w_win +: N];
                  r_owner <= w_win;
                  gnt     <= R'(1) << w_win;
                  r_ptr   <= w_ptr_next;
               end
            end
            S_EXEC: begin
               result <= w_alu_y;
               done   <= R'(1) << r_owner;
            end
            S_DONE: begin
               done <= '0;
            end
            default: begin
               done <= '0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Brief    : Self-checking bench for alu_arbiter: vector table, directed
//            multi-cycle sequences and randomized traffic against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
   localparam int N = 16;
   localparam int R = 4;
   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_OR  = 3'd2;
   localparam logic [2:0] OP_AND = 3'd3;

   logic             clk = 1'b0;
   logic             rst;
   logic [R-1:0]     req;
   logic [3*R-1:0]   opcode_in;
   logic [N*R-1:0]   a_in;
   logic [N*R-1:0]   b_in;
   logic [R-1:0]     gnt;
   logic [R-1:0]     done;
   logic [N-1:0]     result;
   logic             busy;

   int checks   = 0;
   int failures = 0;
   int cycle    = 0;
   int m_ptr    = 0;

   alu_arbiter #(.N(N), .R(R)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .opcode_in (opcode_in),
      .a_in      (a_in),
      .b_in      (b_in),
      .gnt       (gnt),
      .done      (done),
      .result    (result),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Free-running cycle count for grant spacing checks.
   always @(posedge clk) cycle <= cycle + 1;

   typedef struct {
      int         k;
      logic [2:0] op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_slot(input int k, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      opcode_in[3*k +: 3] = op;
      a_in[N*k +: N]      = a;
      b_in[N*k +: N]      = b;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      tick();
      tick();
      rst   = 1'b0;
      m_ptr = 0;
   endtask

   // Reference arithmetic from the operation definitions.
   function automatic logic [15:0] ref_alu(input logic [2:0] op, input int a, input int b);
      int r;
      case (op)
         OP_ADD:  r = (a + b) % 65536;
         OP_SUB:  r = (a - b + 65536) % 65536;
         OP_OR:   r = a | b;
         default: r = a & b;
      endcase
      return 16'(r);
   endfunction

   // Reference round-robin choice: first requester at or after ptr.
   function automatic int ref_winner(input logic [R-1:0] mask, input int ptr);
      for (int i = 0; i < R; i++) begin
         if (mask[(ptr + i) % R]) return (ptr + i) % R;
      end
      return -1;
   endfunction

   task automatic run_single(input int k, input logic [2:0] op, input logic [15:0] a,
                             input logic [15:0] b, input logic [15:0] exp, input string tag);
      req = '0;
      set_slot(k, op, a, b);
      req[k] = 1'b1;
      tick();
      chk({tag, " gnt"}, 32'(gnt), 32'(1 << k));
      chk({tag, " busy_e0"}, 32'(busy), 32'd1);
      chk({tag, " done_e0"}, 32'(done), 32'd0);
      req = '0;
      tick();
      chk({tag, " gnt_off"}, 32'(gnt), 32'd0);
      chk({tag, " done"}, 32'(done), 32'(1 << k));
      chk({tag, " result"}, 32'(result), 32'(exp));
      chk({tag, " busy_e1"}, 32'(busy), 32'd1);
      tick();
      chk({tag, " done_clr"}, 32'(done), 32'd0);
      chk({tag, " busy_clr"}, 32'(busy), 32'd0);
      m_ptr = (k + 1) % R;
   endtask

   task automatic wait_gnt(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (gnt == '0 && n < 8);
   endtask

   initial begin
      int n;
      int last_cyc;
      int prev;
      logic [R-1:0] mask;
      logic [2:0] ops[R];
      logic [15:0] av[R];
      logic [15:0] bv[R];
      int w;

      rst = 1'b1; req = '0; opcode_in = '0; a_in = '0; b_in = '0;
      vecs[0] = '{0, OP_ADD, 16'd40,     16'd2,  16'd42};
      vecs[1] = '{1, OP_SUB, 16'd40,     16'd2,  16'd38};
      vecs[2] = '{1, OP_SUB, 16'd2,      16'd40, 16'hFFDA};
      vecs[3] = '{2, OP_ADD, 16'hFFFF,   16'd1,  16'd0};
      vecs[4] = '{3, OP_OR,  16'd40,     16'd31, 16'd63};
      vecs[5] = '{0, OP_AND, 16'd40,     16'd31, 16'd8};

      // Reset state
      do_reset();
      chk("rst gnt", 32'(gnt), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst result", 32'(result), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);

      // Table-driven single requests
      for (int i = 0; i < 6; i++) begin
         run_single(vecs[i].k, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp,
                    $sformatf("vec%0d", i));
      end

      // All four requesters at once after reset: grants 0,1,2,3 spaced 3 cycles
      do_reset();
      set_slot(0, OP_ADD, 16'd40, 16'd2);
      set_slot(1, OP_SUB, 16'd40, 16'd2);
      set_slot(2, OP_OR,  16'd40, 16'd31);
      set_slot(3, OP_AND, 16'd40, 16'd31);
      req = 4'hF;
      last_cyc = 0;
      for (int g = 0; g < 4; g++) begin
         wait_gnt(n);
         chk($sformatf("all4 gnt%0d", g), 32'(gnt), 32'(1 << g));
         if (g > 0) chk($sformatf("all4 spacing%0d", g), 32'(cycle - last_cyc), 32'd3);
         last_cyc = cycle;
         req[g] = 1'b0;
         tick();
         chk($sformatf("all4 done%0d", g), 32'(done), 32'(1 << g));
         chk($sformatf("all4 result%0d", g), 32'(result),
             32'(ref_alu(opcode_in[3*g +: 3], 40, (g < 2) ? 2 : 31)));
      end

      // Fairness: req0 and req2 held continuously
      do_reset();
      set_slot(0, OP_ADD, 16'd1, 16'd1);
      set_slot(2, OP_ADD, 16'd2, 16'd2);
      req  = 4'b0101;
      prev = -1;
      for (int g = 0; g < 6; g++) begin
         wait_gnt(n);
         chk($sformatf("fair gnt%0d", g), 32'(gnt), 32'((g % 2 == 0) ? 1 : 4));
         if (prev >= 0) chk($sformatf("fair norepeat%0d", g), 32'(gnt != 4'(prev)), 32'd1);
         prev = int'(gnt);
      end
      req = '0;
      tick();
      tick();

      // Operand isolation: owner inputs change during EXEC
      do_reset();
      set_slot(1, OP_ADD, 16'd100, 16'd5);
      req = 4'b0010;
      tick();
      chk("iso gnt", 32'(gnt), 32'h2);
      set_slot(1, OP_SUB, 16'd999, 16'd77);
      req = '0;
      tick();
      chk("iso done", 32'(done), 32'h2);
      chk("iso result", 32'(result), 32'd105);
      tick();

      // Reset in EXEC: no done pulse, everything back to reset values
      set_slot(1, OP_ADD, 16'd7, 16'd8);
      req = 4'b0010;
      tick();
      chk("rexec gnt", 32'(gnt), 32'h2);
      rst = 1'b1;
      req = '0;
      tick();
      chk("rexec gnt0", 32'(gnt), 32'd0);
      chk("rexec done0", 32'(done), 32'd0);
      chk("rexec result0", 32'(result), 32'd0);
      chk("rexec busy0", 32'(busy), 32'd0);
      rst = 1'b0;
      set_slot(3, OP_ADD, 16'd1, 16'd2);
      req = 4'b1010;
      tick();
      chk("rexec nodone", 32'(done), 32'd0);
      chk("rexec first", 32'(gnt), 32'h2);
      req = '0;
      tick();
      chk("rexec result", 32'(result), 32'd15);
      tick();

      // Randomized traffic against the reference model
      do_reset();
      for (int it = 0; it < 80; it++) begin
         mask = 4'($urandom_range(0, 15));
         for (int k = 0; k < R; k++) begin
            ops[k] = 3'($urandom_range(0, 3));
            av[k]  = 16'($urandom);
            bv[k]  = 16'($urandom);
            set_slot(k, ops[k], av[k], bv[k]);
         end
         req = mask;
         w   = ref_winner(mask, m_ptr);
         tick();
         if (w < 0) begin
            chk($sformatf("rnd%0d idle_gnt", it), 32'(gnt), 32'd0);
            chk($sformatf("rnd%0d idle_busy", it), 32'(busy), 32'd0);
         end else begin
            chk($sformatf("rnd%0d gnt", it), 32'(gnt), 32'(1 << w));
            req = '0;
            for (int k = 0; k < R; k++) set_slot(k, 3'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
            tick();
            chk($sformatf("rnd%0d done", it), 32'(done), 32'(1 << w));
            chk($sformatf("rnd%0d result", it), 32'(result), 32'(ref_alu(ops[w], int'(av[w]), int'(bv[w]))));
            tick();
            chk($sformatf("rnd%0d busy", it), 32'(busy), 32'd0);
            m_ptr = (w + 1) % R;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
